keypad_matrix_scanner: RTL and testbench

//  Scans a 4x3 matrix keypad, debounces it and resolves one key at a time. Sits directly upstream of
//  the watch block: drives its 10-bit one-hot keypad input (digits 0-9) as a clean level.

---
 rtl/keypad_matrix_scanner.sv | 274 +++++++++++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scanner.sv
// 4x3 matrix keypad scanner with debounce, single-key resolution and registered level/strobe outputs.
// Optional auto-repeat of key_pulse while a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_matrix_scanner #(
    parameter int ROW_CYCLES      = 2,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_RATE     = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] col_in,
    output logic [3:0] row_out,
    output logic [9:0] key_onehot,
    output logic       key_star,
    output logic       key_hash,
    output logic [3:0] key_code,
    output logic       key_pulse
);

    function automatic int max2(input int a, input int b);
        max2 = (a > b) ? a : b;
    endfunction

    localparam int MAX_P = max2(max2(ROW_CYCLES, DEBOUNCE_CYCLES), max2(REPEAT_DELAY, REPEAT_RATE));
    localparam int CNT_W = $clog2(MAX_P + 1);

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(ROW_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [3:0]       CODE_NONE = 4'hF;
    localparam logic [2:0]       COLS_IDLE = 3'b111;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Exactly one column low is the only pattern that names a single key.
    function automatic logic col_valid(input logic [2:0] c);
        case (c)
            3'b110, 3'b101, 3'b011: col_valid = 1'b1;
            default:                col_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] col_index(input logic [2:0] c);
        case (c)
            3'b110:  col_index = 2'd0;
            3'b101:  col_index = 2'd1;
            3'b011:  col_index = 2'd2;
            default: col_index = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] key_decode(input logic [1:0] row, input logic [1:0] col);
        if (row != 2'd3) begin
            key_decode = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        end else begin
            case (col)
                2'd0:    key_decode = 4'd10;
                2'd1:    key_decode = 4'd0;
                2'd2:    key_decode = 4'd11;
                default: key_decode = CODE_NONE;
            endcase
        end
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [2:0]       col_meta_r, col_sync_r;
    logic [1:0]       row_d1_r, row_d2_r;
    state_t           state_r, state_s;
    logic [1:0]       row_idx_r, row_idx_s;
    logic [CNT_W-1:0] slot_cnt_r, slot_cnt_s;
    logic [CNT_W-1:0] cnt_r, cnt_s, deb_next_s;
    logic [2:0]       cap_cols_r, cap_cols_s;
    logic [3:0]       row_out_r;
    logic [3:0]       key_code_r, code_s;
    logic [9:0]       key_onehot_r, onehot_s;
    logic             key_star_r, key_hash_r, star_s, hash_s;
    logic             key_pulse_r, press_s, rep_fire_s;

    // Two-flop column synchronizer; row_d2_r tags each synchronized sample with the row that produced it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta_r <= COLS_IDLE;
            col_sync_r <= COLS_IDLE;
            row_d1_r   <= 2'd0;
            row_d2_r   <= 2'd0;
        end else begin
            col_meta_r <= col_in;
            col_sync_r <= col_meta_r;
            row_d1_r   <= row_idx_r;
            row_d2_r   <= row_d1_r;
        end
    end

    // Next-state logic: scan, debounce, hold and release of a single key.
    always_comb begin
        state_s    = state_r;
        row_idx_s  = row_idx_r;
        slot_cnt_s = slot_cnt_r;
        cnt_s      = cnt_r;
        cap_cols_s = cap_cols_r;
        code_s     = key_code_r;
        press_s    = 1'b0;
        deb_next_s = sat_inc(cnt_r);
        case (state_r)
            SCAN: begin
                if (slot_cnt_r >= SLOT_LAST) begin
                    slot_cnt_s = CNT_ZERO;
                    if (col_valid(col_sync_r)) begin
                        // The sample belongs to the row driven two cycles ago; drive that row back.
                        state_s    = DEBOUNCE;
                        cap_cols_s = col_sync_r;
                        row_idx_s  = row_d2_r;
                        cnt_s      = CNT_ZERO;
                    end else begin
                        row_idx_s = row_idx_r + 2'd1;
                    end
                end else begin
                    slot_cnt_s = sat_inc(slot_cnt_r);
                end
            end
            DEBOUNCE: begin
                if (row_d2_r != row_idx_r) begin
                    cnt_s = cnt_r;  // sample still from a row driven before the freeze
                end else if (col_sync_r == cap_cols_r) begin
                    if (deb_next_s >= DEB_LAST) begin
                        state_s = HELD;
                        cnt_s   = CNT_ZERO;
                        code_s  = key_decode(row_idx_r, col_index(cap_cols_r));
                        press_s = 1'b1;
                    end else begin
                        cnt_s = deb_next_s;
                    end
                end else begin
                    state_s    = SCAN;
                    cnt_s      = CNT_ZERO;
                    slot_cnt_s = CNT_ZERO;
                    row_idx_s  = row_idx_r + 2'd1;
                end
            end
            HELD: begin
                if (col_sync_r == COLS_IDLE) begin
                    state_s = RELEASE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = HELD;
                end
            end
            RELEASE: begin
                if (col_sync_r != COLS_IDLE) begin
                    state_s = HELD;
                    cnt_s   = CNT_ZERO;
                end else if (deb_next_s >= DEB_LAST) begin
                    state_s    = SCAN;
                    cnt_s      = CNT_ZERO;
                    slot_cnt_s = CNT_ZERO;
                    row_idx_s  = 2'd0;
                    code_s     = CODE_NONE;
                end else begin
                    cnt_s = deb_next_s;
                end
            end
            default: begin
                state_s    = SCAN;
                cnt_s      = CNT_ZERO;
                slot_cnt_s = CNT_ZERO;
                row_idx_s  = 2'd0;
                code_s     = CODE_NONE;
            end
        endcase
    end

    // Level outputs are a pure decode of the next key code, so they can never disagree with it.
    always_comb begin
        onehot_s = 10'b0;
        star_s   = 1'b0;
        hash_s   = 1'b0;
        if (code_s <= 4'd9) begin
            onehot_s = 10'b00_0000_0001 << code_s;
        end else if (code_s == 4'd10) begin
            star_s = 1'b1;
        end else if (code_s == 4'd11) begin
            hash_s = 1'b1;
        end else begin
            onehot_s = 10'b0;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_DELAY_C = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] REP_RATE_C  = CNT_W'(REPEAT_RATE);

    logic [CNT_W-1:0] rep_cnt_r, rep_cnt_s, rep_next_s;
    logic             rep_first_r, rep_first_s;

    // Repeat timer runs only while staying in HELD; the first interval is the longer delay.
    always_comb begin
        rep_cnt_s   = CNT_ZERO;
        rep_first_s = 1'b1;
        rep_fire_s  = 1'b0;
        rep_next_s  = sat_inc(rep_cnt_r);
        if ((state_r == HELD) && (state_s == HELD)) begin
            if (rep_next_s >= (rep_first_r ? REP_DELAY_C : REP_RATE_C)) begin
                rep_fire_s  = 1'b1;
                rep_cnt_s   = CNT_ZERO;
                rep_first_s = 1'b0;
            end else begin
                rep_cnt_s   = rep_next_s;
                rep_first_s = rep_first_r;
            end
        end else begin
            rep_cnt_s   = CNT_ZERO;
            rep_first_s = 1'b1;
        end
    end

    // Repeat timer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_r   <= CNT_ZERO;
            rep_first_r <= 1'b1;
        end else begin
            rep_cnt_r   <= rep_cnt_s;
            rep_first_r <= rep_first_s;
        end
    end
`else
    assign rep_fire_s = 1'b0;
`endif

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= SCAN;
            row_idx_r    <= 2'd0;
            slot_cnt_r   <= CNT_ZERO;
            cnt_r        <= CNT_ZERO;
            cap_cols_r   <= COLS_IDLE;
            row_out_r    <= 4'b1110;
            key_code_r   <= CODE_NONE;
            key_onehot_r <= 10'b0;
            key_star_r   <= 1'b0;
            key_hash_r   <= 1'b0;
            key_pulse_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            row_idx_r    <= row_idx_s;
            slot_cnt_r   <= slot_cnt_s;
            cnt_r        <= cnt_s;
            cap_cols_r   <= cap_cols_s;
            row_out_r    <= ~(4'b0001 << row_idx_s);
            key_code_r   <= code_s;
            key_onehot_r <= onehot_s;
            key_star_r   <= star_s;
            key_hash_r   <= hash_s;
            key_pulse_r  <= press_s | rep_fire_s;
        end
    end

    assign row_out    = row_out_r;
    assign key_code   = key_code_r;
    assign key_onehot = key_onehot_r;
    assign key_star   = key_star_r;
    assign key_hash   = key_hash_r;
    assign key_pulse  = key_pulse_r;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner: a keypad model closes row/column contacts,
// a table walks every key, and hand-written sequences cover bounce, multi-key, reset and repeat.
module tb_keypad_matrix_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  col_in;
    logic [3:0]  row_out;
    logic [9:0]  key_onehot;
    logic        key_star, key_hash, key_pulse;
    logic [3:0]  key_code;
    logic [11:0] keys = 12'b0;   // bit row*3+col = key closed

    int n_checks  = 0;
    int n_fail    = 0;
    int pulse_cnt = 0;
    int cyc       = 0;
    int pulse_at[$];

    always #5 clk = ~clk;

    keypad_matrix_scanner dut (
        .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out),
        .key_onehot(key_onehot), .key_star(key_star), .key_hash(key_hash),
        .key_code(key_code), .key_pulse(key_pulse)
    );

    // Passive keypad: a closed key pulls its column low while its row is driven low.
    always_comb begin
        col_in = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (!row_out[r] && keys[r*3+c]) col_in[c] = 1'b0;
    end

    // Pulse recorder and output exclusivity monitor.
    always @(negedge clk) begin
        cyc++;
        if (key_pulse === 1'b1) begin
            pulse_cnt++;
            pulse_at.push_back(cyc);
        end
        if (!rst) begin
            n_checks++;
            if ((int'(|key_onehot) + int'(key_star) + int'(key_hash) > 1) ||
                ((key_code == 4'hF) && ((|key_onehot) || key_star || key_hash))) begin
                n_fail++;
                $display("FAIL exclusive_levels: got onehot=%b star=%b hash=%b code=%h required at most one level, none when code=F",
                         key_onehot, key_star, key_hash, key_code);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_pulse(input string name, input int bound);
        int n;
        n = 0;
        while (key_pulse !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check({name, "_pulse_seen"}, {31'b0, key_pulse}, 32'd1);
    endtask

    task automatic wait_clear(input string name, input int bound);
        int n;
        n = 0;
        while (key_code !== 4'hF && n < bound) begin
            tick();
            n++;
        end
        check({name, "_cleared_code"}, {28'b0, key_code}, 32'hF);
        check({name, "_cleared_levels"}, {20'b0, key_onehot, key_star, key_hash}, 32'd0);
    endtask

    typedef struct {
        int         pos;
        int         hold;
        logic [3:0] code;
        logic [9:0] onehot;
        logic       star;
        logic       hash;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int p0, t0;
        logic lost;
        vecs[0]  = '{0,  30, 4'd1,  10'b0000000010, 1'b0, 1'b0};
        vecs[1]  = '{1,  30, 4'd2,  10'b0000000100, 1'b0, 1'b0};
        vecs[2]  = '{2,  30, 4'd3,  10'b0000001000, 1'b0, 1'b0};
        vecs[3]  = '{3,  30, 4'd4,  10'b0000010000, 1'b0, 1'b0};
        vecs[4]  = '{4, 100, 4'd5,  10'b0000100000, 1'b0, 1'b0};
        vecs[5]  = '{5,  30, 4'd6,  10'b0001000000, 1'b0, 1'b0};
        vecs[6]  = '{6,  30, 4'd7,  10'b0010000000, 1'b0, 1'b0};
        vecs[7]  = '{7,  30, 4'd8,  10'b0100000000, 1'b0, 1'b0};
        vecs[8]  = '{8,  30, 4'd9,  10'b1000000000, 1'b0, 1'b0};
        vecs[9]  = '{9,  30, 4'd10, 10'b0000000000, 1'b1, 1'b0};
        vecs[10] = '{10, 30, 4'd0,  10'b0000000001, 1'b0, 1'b0};
        vecs[11] = '{11, 30, 4'd11, 10'b0000000000, 1'b0, 1'b1};

        // Reset values, then row rotation two clocks per row.
        repeat (3) tick();
        check("rst_row_out", {28'b0, row_out}, 32'hE);
        check("rst_code", {28'b0, key_code}, 32'hF);
        check("rst_levels", {20'b0, key_onehot, key_star, key_hash}, 32'd0);
        check("rst_pulse", {31'b0, key_pulse}, 32'd0);
        rst = 1'b0;
        begin
            logic [3:0] rows_exp [8];
            rows_exp = '{4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b1110};
            for (int i = 0; i < 8; i++) begin
                tick();
                check($sformatf("row_scan_%0d", i), {28'b0, row_out}, {28'b0, rows_exp[i]});
            end
        end

        // Every key: one pulse, correct outputs while held, clear 22 clocks after release.
        for (int i = 0; i < 12; i++) begin
            p0 = pulse_cnt;
            keys = 12'b0;
            keys[vecs[i].pos] = 1'b1;
            wait_pulse($sformatf("key%0d", i), 50);
            check($sformatf("key%0d_code", i), {28'b0, key_code}, {28'b0, vecs[i].code});
            check($sformatf("key%0d_levels", i), {20'b0, key_onehot, key_star, key_hash},
                  {20'b0, vecs[i].onehot, vecs[i].star, vecs[i].hash});
            repeat (vecs[i].hold) tick();
            check($sformatf("key%0d_one_pulse", i), pulse_cnt - p0, 32'd1);
            keys = 12'b0;
            repeat (20) tick();
            check($sformatf("key%0d_held_after_release", i), {28'b0, key_code}, {28'b0, vecs[i].code});
            wait_clear($sformatf("key%0d", i), 10);
            repeat (4) tick();
        end

        // Two keys in the same row: multi-key pattern is ignored.
        p0 = pulse_cnt;
        keys = 12'b000000000011;
        repeat (60) tick();
        check("multikey_no_pulse", pulse_cnt - p0, 32'd0);
        check("multikey_code", {28'b0, key_code}, 32'hF);
        keys = 12'b0;
        repeat (10) tick();

        // Key 7 bounces every 3 cycles, then settles low.
        p0 = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            keys[6] = (i % 2 == 0);
            repeat (3) tick();
            check($sformatf("bounce_quiet_%0d", i), {28'b0, key_code}, 32'hF);
        end
        keys[6] = 1'b1;
        wait_pulse("bounce", 40);
        check("bounce_code", {28'b0, key_code}, 32'd7);
        repeat (20) tick();
        check("bounce_one_pulse", pulse_cnt - p0, 32'd1);
        keys = 12'b0;
        wait_clear("bounce", 40);
        repeat (4) tick();

        // '#' held, '0' added, '#' released: '#' stays until everything is released.
        p0 = pulse_cnt;
        keys[11] = 1'b1;
        wait_pulse("hash", 50);
        check("hash_level", {31'b0, key_hash}, 32'd1);
        check("hash_code", {28'b0, key_code}, 32'd11);
        keys[10] = 1'b1;
        repeat (30) tick();
        check("hash_zero_both_code", {28'b0, key_code}, 32'd11);
        check("hash_zero_both_onehot", {22'b0, key_onehot}, 32'd0);
        keys[11] = 1'b0;
        repeat (30) tick();
        check("zero_only_still_hash", {31'b0, key_hash}, 32'd1);
        check("zero_only_code", {28'b0, key_code}, 32'd11);
        check("zero_only_onehot", {22'b0, key_onehot}, 32'd0);
        check("hash_one_pulse", pulse_cnt - p0, 32'd1);
        keys = 12'b0;
        wait_clear("hash", 40);
        keys[10] = 1'b1;
        wait_pulse("zero_after", 50);
        check("zero_after_code", {28'b0, key_code}, 32'd0);
        check("zero_after_onehot", {22'b0, key_onehot}, 32'd1);
        keys = 12'b0;
        wait_clear("zero_after", 40);
        repeat (4) tick();

        // Reset while key 3 is held, then re-acceptance.
        p0 = pulse_cnt;
        keys[2] = 1'b1;
        wait_pulse("k3", 50);
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_code", {28'b0, key_code}, 32'hF);
        check("midrst_onehot", {22'b0, key_onehot}, 32'd0);
        check("midrst_row", {28'b0, row_out}, 32'hE);
        tick();
        rst = 1'b0;
        wait_pulse("k3_again", 50);
        check("k3_again_code", {28'b0, key_code}, 32'd3);
        check("k3_again_onehot", {22'b0, key_onehot}, 32'h8);
        check("k3_two_pulses", pulse_cnt - p0, 32'd2);
        keys = 12'b0;
        wait_clear("k3", 40);
        repeat (4) tick();

        // Key 9 held for 1000 cycles: repeat pulses only with auto-repeat built in.
        p0 = pulse_at.size();
        keys[8] = 1'b1;
        wait_pulse("k9", 50);
        lost = 1'b0;
        for (int i = 0; i < 990; i++) begin
            tick();
            if (key_onehot !== 10'b1000000000) lost = 1'b1;
        end
        check("k9_level_steady", {31'b0, lost}, 32'd0);
`ifdef KEYPAD_AUTOREPEAT_EN
        check("k9_pulse_count", pulse_at.size() - p0, 32'd4);
        if (pulse_at.size() - p0 >= 4) begin
            t0 = pulse_at[p0];
            check("k9_rep1", pulse_at[p0+1] - t0, 32'd500);
            check("k9_rep2", pulse_at[p0+2] - t0, 32'd700);
            check("k9_rep3", pulse_at[p0+3] - t0, 32'd900);
        end
`else
        t0 = 0;
        check("k9_pulse_count", pulse_at.size() - p0 + t0, 32'd1);
`endif
        keys = 12'b0;
        wait_clear("k9", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
